// File: rtl/lcd_pkg.sv
// LCD DMA fetch scheduler shared types.
// State encoding and default sizing.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WAIT_SPACE,
    REQ,
    DATA,
    HALT
  } dma_state_t;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_BURST = 8;
  localparam int DEF_FW    = 20;

endpackage

// File: rtl/lcd_dma_ctrl.sv
// Frame buffer fetch scheduler feeding the LCD pixel FIFO.
// Issues space-checked read bursts and pushes returned beats.
module lcd_dma_ctrl
  import lcd_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int BURST = DEF_BURST,
  parameter int FW    = DEF_FW
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          enable,
  input  logic [31:0]   base_addr,
  input  logic [FW-1:0] frame_words,
  input  logic [5:0]    fifo_cnt,
  input  logic          fifo_pull,
  input  logic          fifo_empty,
  output logic          fifo_push,
  output logic [31:0]   fifo_wdata,
  output logic          fifo_flush,
  output logic          m_req,
  output logic [31:0]   m_addr,
  output logic [4:0]    m_len,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [31:0]   m_rdata,
  input  logic          m_err,
  output logic          busy,
  output logic          frame_done,
  output logic          underflow,
  output logic          bus_err
);

  dma_state_t    state, nstate;
  logic          en_q;
  logic [31:0]   addr;
  logic [FW-1:0] remaining;
  logic [4:0]    bleft;
  logic          done_q;
  logic          uflow_q;
  logic          berr_q;

  logic [6:0]    len;
  logic [4:0]    len_m1;
  logic          space_ok;
  logic          beat;
  logic          good;
  logic          last;

  // Burst sizing, FIFO space check and beat qualification.
  always_comb begin
    len = 7'(BURST);
    if (remaining < FW'(BURST))
      len = remaining[6:0];
    len_m1   = 5'(len - 7'd1);
    space_ok = ({1'b0, fifo_cnt} + len) <= 7'(DEPTH);
    beat     = (state == DATA) && m_rvalid;
    good     = beat && !m_err;
    last     = good && (bleft == 5'd0);
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) state <= IDLE;
    else          state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:       if (enable && !en_q) nstate = FLUSH;
      FLUSH:      nstate = WAIT_SPACE;
      WAIT_SPACE: begin
        if (!enable)       nstate = IDLE;
        else if (space_ok) nstate = REQ;
      end
      REQ:        if (m_gnt) nstate = DATA;
      DATA: begin
        if (beat && m_err) nstate = HALT;
        else if (last)     nstate = WAIT_SPACE;
      end
      HALT:       if (!enable) nstate = IDLE;
      default:    nstate = IDLE;
    endcase
  end

  // Address, word count, beat counter and status flags.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      en_q      <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      bleft     <= '0;
      done_q    <= 1'b0;
      uflow_q   <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      en_q   <= enable;
      done_q <= 1'b0;
      if (state == FLUSH)
        uflow_q <= 1'b0;
      else if (fifo_pull && fifo_empty)
        uflow_q <= 1'b1;
      if (beat && m_err)
        berr_q <= 1'b1;
      if (state == FLUSH) begin
        addr      <= {base_addr[31:2], 2'b00};
        remaining <= frame_words;
        berr_q    <= 1'b0;
      end
      if (state == REQ && m_gnt)
        bleft <= len_m1;
      if (good) begin
        bleft <= bleft - 5'd1;
        if (last && remaining == FW'(1)) begin
          done_q    <= 1'b1;
          addr      <= {base_addr[31:2], 2'b00};
          remaining <= frame_words;
        end else begin
          addr <= addr + 32'd4;
          if (remaining != '0)
            remaining <= remaining - FW'(1);
        end
      end
    end
  end

  // Output decode, forced low while in reset.
  always_comb begin
    m_req      = HRESETn && (state == REQ);
    m_addr     = m_req ? addr : 32'd0;
    m_len      = m_req ? len_m1 : 5'd0;
    fifo_push  = HRESETn && good;
    fifo_wdata = fifo_push ? m_rdata : 32'd0;
    fifo_flush = HRESETn && (state == FLUSH);
    busy       = HRESETn && (state != IDLE);
    frame_done = HRESETn && done_q;
    underflow  = uflow_q;
    bus_err    = berr_q;
  end

endmodule

// File: tb/tb_lcd_dma_ctrl.sv
// Directed bench for the LCD DMA fetch scheduler.
// Drives the bus and FIFO counts by hand.
module tb_lcd_dma_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic        enable;
  logic [31:0] base_addr;
  logic [19:0] frame_words;
  logic [5:0]  fifo_cnt;
  logic        fifo_pull;
  logic        fifo_empty;
  logic        fifo_push;
  logic [31:0] fifo_wdata;
  logic        fifo_flush;
  logic        m_req;
  logic [31:0] m_addr;
  logic [4:0]  m_len;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        busy;
  logic        frame_done;
  logic        underflow;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] dseed = 32'hA500_0000;

  lcd_dma_ctrl #(.DEPTH(32), .BURST(8), .FW(20)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .enable      (enable),
    .base_addr   (base_addr),
    .frame_words (frame_words),
    .fifo_cnt    (fifo_cnt),
    .fifo_pull   (fifo_pull),
    .fifo_empty  (fifo_empty),
    .fifo_push   (fifo_push),
    .fifo_wdata  (fifo_wdata),
    .fifo_flush  (fifo_flush),
    .m_req       (m_req),
    .m_addr      (m_addr),
    .m_len       (m_len),
    .m_gnt       (m_gnt),
    .m_rvalid    (m_rvalid),
    .m_rdata     (m_rdata),
    .m_err       (m_err),
    .busy        (busy),
    .frame_done  (frame_done),
    .underflow   (underflow),
    .bus_err     (bus_err)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int maxc);
    int k;
    k = 0;
    while (m_req !== 1'b1 && k < maxc) begin
      tick();
      k++;
    end
    chk("req_wait", {31'd0, m_req}, 32'd1);
  endtask

  task automatic run_burst(input int n, input int gdly,
                           input int err_at, input int dis_at,
                           input logic [31:0] ea,
                           input logic [4:0] el);
    logic pe;
    chk("req", {31'd0, m_req}, 32'd1);
    chk("addr", m_addr, ea);
    chk("len", {27'd0, m_len}, {27'd0, el});
    for (int g = 0; g < gdly; g++) begin
      tick();
      chk("addr_hold", m_addr, ea);
      chk("len_hold", {27'd0, m_len}, {27'd0, el});
    end
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (i == dis_at) enable = 1'b0;
      dseed    = dseed + 32'h0001_0003;
      m_rvalid = 1'b1;
      m_rdata  = dseed;
      m_err    = (i == err_at);
      pe = (err_at == 0) || (i < err_at);
      #1;
      chk("push", {31'd0, fifo_push}, {31'd0, pe});
      if (pe) chk("wdata", fifo_wdata, dseed);
      tick();
      if (pe) fifo_cnt = fifo_cnt + 6'd1;
    end
    m_rvalid = 1'b0;
    m_err    = 1'b0;
  endtask

  initial begin
    HRESETn     = 1'b0;
    enable      = 1'b0;
    base_addr   = 32'h0000_1002;
    frame_words = 20'd16;
    fifo_cnt    = 6'd0;
    fifo_pull   = 1'b0;
    fifo_empty  = 1'b0;
    m_gnt       = 1'b0;
    m_rvalid    = 1'b1;
    m_rdata     = 32'hDEAD_BEEF;
    m_err       = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_req", {31'd0, m_req}, 32'd0);
    chk("rst_addr", m_addr, 32'd0);
    chk("rst_push", {31'd0, fifo_push}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flush", {31'd0, fifo_flush}, 32'd0);
    chk("rst_flags", {30'd0, underflow, bus_err}, 32'd0);
    m_rvalid = 1'b0;
    HRESETn  = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    enable = 1'b1;
    tick();
    chk("flush1", {31'd0, fifo_flush}, 32'd1);
    chk("busy1", {31'd0, busy}, 32'd1);
    tick();
    chk("flush1_end", {31'd0, fifo_flush}, 32'd0);
    chk("ws_noreq", {31'd0, m_req}, 32'd0);
    tick();
    chk("req_lat", {31'd0, m_req}, 32'd1);
    run_burst(8, 0, 0, 0, 32'h1000, 5'd7);
    chk("mid_nodone", {31'd0, frame_done}, 32'd0);
    wait_req(3);
    run_burst(8, 0, 0, 0, 32'h1020, 5'd7);
    chk("done1", {31'd0, frame_done}, 32'd1);
    tick();
    chk("done1_end", {31'd0, frame_done}, 32'd0);
    wait_req(3);
    run_burst(8, 0, 0, 0, 32'h1000, 5'd7);
    wait_req(3);
    run_burst(8, 0, 0, 0, 32'h1020, 5'd7);
    chk("done2", {31'd0, frame_done}, 32'd1);
    chk("cnt_full", {26'd0, fifo_cnt}, 32'd32);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_noreq", {31'd0, m_req}, 32'd0);
    end
    fifo_cnt = 6'd25;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c25_noreq", {31'd0, m_req}, 32'd0);
    end
    fifo_cnt = 6'd24;
    wait_req(2);
    run_burst(8, 5, 0, 3, 32'h1000, 5'd7);
    chk("dis_busy_ws", {31'd0, busy}, 32'd1);
    tick();
    chk("dis_idle", {31'd0, busy}, 32'd0);
    chk("dis_noreq", {31'd0, m_req}, 32'd0);

    fifo_cnt    = 6'd0;
    frame_words = 20'd10;
    tick();
    enable = 1'b1;
    tick();
    chk("flush2", {31'd0, fifo_flush}, 32'd1);
    tick();
    tick();
    chk("req_lat2", {31'd0, m_req}, 32'd1);
    run_burst(8, 0, 0, 0, 32'h1000, 5'd7);
    wait_req(3);
    run_burst(2, 0, 0, 0, 32'h1020, 5'd1);
    chk("done10", {31'd0, frame_done}, 32'd1);
    wait_req(3);
    run_burst(8, 0, 3, 0, 32'h1000, 5'd7);
    chk("berr_set", {31'd0, bus_err}, 32'd1);
    chk("berr_cnt", {26'd0, fifo_cnt}, 32'd12);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_noreq", {31'd0, m_req}, 32'd0);
    end
    chk("halt_busy", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    tick();
    chk("halt_idle", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    tick();
    chk("flush3", {31'd0, fifo_flush}, 32'd1);
    fifo_cnt = 6'd0;
    tick();
    chk("berr_clr", {31'd0, bus_err}, 32'd0);

    fifo_pull  = 1'b1;
    fifo_empty = 1'b1;
    tick();
    fifo_pull  = 1'b0;
    fifo_empty = 1'b0;
    chk("uflow_set", {31'd0, underflow}, 32'd1);
    wait_req(3);
    run_burst(8, 0, 0, 0, 32'h1000, 5'd7);
    wait_req(3);
    run_burst(2, 0, 0, 0, 32'h1020, 5'd1);
    chk("done_uf", {31'd0, frame_done}, 32'd1);
    chk("uflow_wrap", {31'd0, underflow}, 32'd1);
    enable = 1'b0;
    tick();
    tick();
    chk("uflow_idle", {31'd0, underflow}, 32'd1);
    enable = 1'b1;
    tick();
    chk("flush4", {31'd0, fifo_flush}, 32'd1);
    tick();
    chk("uflow_clr", {31'd0, underflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_dma_ctrl.md
# lcd_dma_ctrl

Fetch scheduler for the LCD pixel FIFO. It walks a frame buffer in system memory and issues fixed-size read bursts on a simple request/grant bus-master port. It issues a burst only when the FIFO has room for every beat, and pushes each returned word straight into the FIFO. It sits between the LCD register block (base address, frame size, enable) and `lcd_fifo`, and it owns the FIFO's push and flush inputs.

## Interface
- `DEPTH`, 32: FIFO depth in words; must match `lcd_fifo`.
- `BURST`, 8: maximum beats per burst, 1..DEPTH.
- `FW`, 20: width of the frame word count.
- `HCLK` in 1: single clock; everything is on the rising edge.
- `HRESETn` in 1: synchronous, active-low reset.
- `enable` in 1: a level; the 0→1 edge starts a frame.
- `base_addr` in 32: frame buffer byte address; bits [1:0] are ignored.
- `frame_words` in FW: words per frame, ≥1; sampled only in FLUSH and at frame wrap.
- `fifo_cnt` in 6: FIFO occupancy.
- `fifo_pull` in 1: monitor of the FIFO pull.
- `fifo_empty` in 1: monitor of the FIFO empty flag.
- `fifo_push` out 1: write strobe to the FIFO.
- `fifo_wdata` out 32: write data to the FIFO.
- `fifo_flush` out 1: flush strobe to the FIFO.
- `m_req` out 1: burst request.
- `m_addr` out 32: burst start address, word-aligned.
- `m_len` out 5: burst length in beats minus 1.
- `m_gnt` in 1: request accepted.
- `m_rvalid` in 1: read data beat valid.
- `m_rdata` in 32: read data.
- `m_err` in 1: error response, qualified by `m_rvalid`.
- `busy` out 1: high when the state is not IDLE.
- `frame_done` out 1: one-cycle pulse.
- `underflow` out 1: sticky flag.
- `bus_err` out 1: sticky flag.

## Operation
- States are IDLE, FLUSH, WAIT_SPACE, REQ, DATA and HALT.
- **IDLE.** On a rising edge of `enable`, go to FLUSH.
- **FLUSH.** Lasts exactly one cycle.
  - Assert `fifo_flush`.
  - Load `addr` with `{base_addr[31:2],2'b00}` and `remaining` with `frame_words`.
  - Clear `underflow` and `bus_err`.
  - Go to WAIT_SPACE.
- **Burst length.** `len = min(BURST, remaining)`.
- **WAIT_SPACE.**
  - If `enable` is 0, go to IDLE.
  - Else, when `fifo_cnt + len <= DEPTH` (7-bit compare), go to REQ.
- **REQ.**
  - Drive `m_req`=1, `m_addr`=`addr` and `m_len`=`len-1`.
  - All three are held stable until `m_gnt`; then go to DATA.
- **DATA.**
  - Each `m_rvalid` beat with `m_err`=0 does the following:
    - `fifo_push`=1 and `fifo_wdata`=`m_rdata`, combinationally in the same cycle.
    - `addr += 4` and `remaining -= 1`.
  - After the last beat:
    - If `remaining` is 0: pulse `frame_done`, reload `addr` and `remaining` from the inputs, then go to WAIT_SPACE (no flush).
    - Otherwise: go to WAIT_SPACE.
- **Disable.** Deasserting `enable` mid-burst does not abort the burst. All beats are accepted and pushed, then the block goes to IDLE through WAIT_SPACE.
- **Bus error.** An `m_rvalid` beat with `m_err`=1:
  - is not pushed;
  - sets `bus_err`;
  - sends the block to HALT.
  - HALT waits for `enable`=0 and then goes to IDLE.
  - Any later beats of that burst are ignored.
- **Underflow.** `underflow` is set when `fifo_pull && fifo_empty`, in any state. It is cleared only in FLUSH or by reset.
- **Address wrap.** `addr` wraps modulo 2^32. `remaining` never underflows.

## Timing
- Reset (`HRESETn`=0 at a clock edge) forces:
  - state IDLE;
  - `addr`=0 and `remaining`=0;
  - `underflow`=0, `bus_err`=0 and the registered enable-edge detector = 0.
- In reset every output is 0: `m_req`, `m_addr`, `m_len`, `fifo_push`, `fifo_wdata`, `fifo_flush`, `busy` and `frame_done`.
- Reset mid-burst drops any outstanding beats. The bus side is assumed to be reset by the same `HRESETn`.
- Latency from the `enable` edge:
  - `fifo_flush` follows one cycle after the sampled rising edge;
  - the first `m_req` follows two cycles after FLUSH when the FIFO is empty.
- `fifo_cnt` from the FIFO lags a push by one cycle. WAIT_SPACE is entered on the edge that registers the last push, so the space check always sees the updated count.
- At most one burst is outstanding.
- `m_rvalid` may not be stalled. The space check guarantees `fifo_full`=0 on every pushed beat; a push while full is a checker error.
- `m_rvalid` outside DATA is ignored.
- `frame_done` is registered and is high for exactly one cycle, in the cycle after the last beat.

## Structure
- Package `lcd_pkg`:
  - `typedef enum logic [2:0] {IDLE, FLUSH, WAIT_SPACE, REQ, DATA, HALT} dma_state_t;`
  - `localparam` defaults for DEPTH and BURST.
- No sub-module.
- Space check and burst-length calculation are inline combinational logic.
- Flag and counter registers live in one `always_ff` with synchronous `!HRESETn`.

## Test plan
- Reset then enable, with `base_addr`=0x1000, `frame_words`=16, BURST=8 and an idle consumer:
  - flush pulse first;
  - bursts at 0x1000 (`m_len`=7) and 0x1020;
  - 16 pushes and `frame_done`;
  - then no request until the FIFO drains below 25.
- With `frame_words`=10: bursts of 8 then 2 beats (`m_len`=1); `frame_done`; the next request is at `base_addr` again with `m_len`=7.
- With `fifo_cnt`=25 held: no `m_req`. Drop `fifo_cnt` to 24: `m_req` goes high within 2 cycles.
- `m_gnt` delayed 5 cycles: `m_addr` and `m_len` are stable throughout. Deassert `enable` during DATA: all 8 beats are pushed, then IDLE with `busy`=0.
- `m_err` on beat 3: 2 pushes, `bus_err`=1, no further `m_req`. `enable` low then high: flush and `bus_err` cleared.
- `fifo_pull` while `fifo_empty`: `underflow`=1 stays set through a frame wrap and clears only on a re-enable flush.
